synth_cmd_fifo: RTL and testbench

SYNTH_CMD_FIFO -- requirements
Module: synth_cmd_fifo

---
 rtl/synth_cmd_fifo.sv | 118 +++++++++++
 tb/tb_synth_cmd_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/synth_cmd_fifo.sv
// rtl/synth_cmd_fifo.sv - command FIFO with decode stage driving synth core registers
module synth_cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] synth_ctrl,
    input  logic [7:0] synth_data,
    input  logic       core_ready,
    input  logic       err_clr,
    output logic       fifo_full,
    output logic       frame_tick,
    output logic       frame_done,
    output logic [7:0] note_num,
    output logic       note_on,
    output logic [7:0] volume,
    output logic [7:0] wave_sel,
    output logic       ovf_err,
    output logic       bad_cmd
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] HIGH_WM = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    logic          at_depth;
    logic          accept;
    logic          ovf_set;
    logic          bad_set;
    logic [7:0]    dec_ctrl;
    logic [7:0]    dec_data;

    always_comb begin
        push     = (synth_ctrl != 8'h00);
        pop      = (count != '0) && core_ready;
        at_depth = (count == DEPTH_C);
        // A pop at full frees the slot the same cycle, so the push still lands.
        accept   = push && (!at_depth || pop);
        ovf_set  = push && at_depth && !pop;
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {synth_ctrl, synth_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            dec_ctrl  <= 8'h00;
            dec_data  <= 8'h00;
        end else begin
            count     <= count_next;
            fifo_full <= (count_next >= HIGH_WM);
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // An idle code in the decode register means nothing was popped.
            if (pop) begin
                dec_ctrl <= mem[rd_ptr][15:8];
                dec_data <= mem[rd_ptr][7:0];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end else begin
                dec_ctrl <= 8'h00;
                dec_data <= 8'h00;
            end
        end
    end

    always_comb begin
        bad_set = 1'b0;
        case (dec_ctrl)
            8'h00, 8'h01, 8'h81, 8'h41, 8'h11, 8'h20: bad_set = 1'b0;
            default:                                   bad_set = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
            frame_done <= 1'b0;
            note_num   <= 8'h00;
            volume     <= 8'h00;
            wave_sel   <= 8'h00;
            ovf_err    <= 1'b0;
            bad_cmd    <= 1'b0;
        end else begin
            frame_tick <= (dec_ctrl == 8'h01);
            frame_done <= (dec_ctrl == 8'h81);
            if (dec_ctrl == 8'h41) note_num <= dec_data;
            if (dec_ctrl == 8'h11) volume   <= dec_data;
            if (dec_ctrl == 8'h20) wave_sel <= dec_data;
            // Setting events win over a same-cycle clear.
            ovf_err <= ovf_set || (ovf_err && !err_clr);
            bad_cmd <= bad_set || (bad_cmd && !err_clr);
        end
    end

    assign note_on = (note_num != 8'h00);
endmodule

// File: tb/tb_synth_cmd_fifo.sv
// tb/tb_synth_cmd_fifo.sv - directed self-checking bench for synth_cmd_fifo
module tb_synth_cmd_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] synth_ctrl;
    logic [7:0] synth_data;
    logic       core_ready;
    logic       err_clr;
    logic       fifo_full;
    logic       frame_tick;
    logic       frame_done;
    logic [7:0] note_num;
    logic       note_on;
    logic [7:0] volume;
    logic [7:0] wave_sel;
    logic       ovf_err;
    logic       bad_cmd;

    int total = 0;
    int bad   = 0;

    synth_cmd_fifo #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .synth_ctrl (synth_ctrl),
        .synth_data (synth_data),
        .core_ready (core_ready),
        .err_clr    (err_clr),
        .fifo_full  (fifo_full),
        .frame_tick (frame_tick),
        .frame_done (frame_done),
        .note_num   (note_num),
        .note_on    (note_on),
        .volume     (volume),
        .wave_sel   (wave_sel),
        .ovf_err    (ovf_err),
        .bad_cmd    (bad_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] c, input logic [7:0] d,
                        input logic rdy, input logic clr);
        synth_ctrl = c;
        synth_data = d;
        core_ready = rdy;
        err_clr    = clr;
        @(posedge clk);
        #1;
        synth_ctrl = 8'h00;
        synth_data = 8'h00;
        core_ready = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_full"}, {7'b0, fifo_full}, 8'h00);
        chk({tag, "_tick"}, {7'b0, frame_tick}, 8'h00);
        chk({tag, "_done"}, {7'b0, frame_done}, 8'h00);
        chk({tag, "_note"}, note_num, 8'h00);
        chk({tag, "_on"},   {7'b0, note_on}, 8'h00);
        chk({tag, "_vol"},  volume, 8'h00);
        chk({tag, "_wave"}, wave_sel, 8'h00);
        chk({tag, "_ovf"},  {7'b0, ovf_err}, 8'h00);
        chk({tag, "_bad"},  {7'b0, bad_cmd}, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        synth_ctrl = 8'h00; synth_data = 8'h00; core_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        reset = 1'b0;

        // single note: visible two edges after the push, not one
        step(8'h41, 8'h3C, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("lat_early", note_num, 8'h00);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("note_num", note_num, 8'h3C);
        chk("note_on", {7'b0, note_on}, 8'h01);

        // nine pushes with core stalled
        for (int i = 1; i <= 9; i++) begin
            step(8'h11, 8'(i), 1'b0, 1'b0);
            if (i == 5 || i == 6) chk($sformatf("full_p%0d", i), {7'b0, fifo_full}, (i >= 6) ? 8'h01 : 8'h00);
            if (i == 8) chk("ovf_p8", {7'b0, ovf_err}, 8'h00);
        end
        chk("ovf_p9", {7'b0, ovf_err}, 8'h01);
        for (int k = 1; k <= 10; k++) begin
            step(8'h00, 8'h00, 1'b1, 1'b0);
            if (k >= 2 && k <= 9) chk($sformatf("drain_vol%0d", k - 1), volume, 8'(k - 1));
        end
        chk("drain_vol_end", volume, 8'h08);
        chk("drain_full", {7'b0, fifo_full}, 8'h00);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", {7'b0, ovf_err}, 8'h00);

        // frame pulses then wave select
        step(8'h01, 8'h00, 1'b1, 1'b0);
        step(8'h81, 8'h00, 1'b1, 1'b0);
        chk("tick_pre", {7'b0, frame_tick}, 8'h00);
        step(8'h20, 8'h05, 1'b1, 1'b0);
        chk("tick_on", {7'b0, frame_tick}, 8'h01);
        chk("done_pre", {7'b0, frame_done}, 8'h00);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("tick_off", {7'b0, frame_tick}, 8'h00);
        chk("done_on", {7'b0, frame_done}, 8'h01);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("done_off", {7'b0, frame_done}, 8'h00);
        chk("wave_sel", wave_sel, 8'h05);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) step(8'h11, 8'hA0 + 8'(i), 1'b0, 1'b0);
        chk("full8", {7'b0, fifo_full}, 8'h01);
        step(8'h11, 8'hAA, 1'b1, 1'b0);
        chk("pp_ovf", {7'b0, ovf_err}, 8'h00);
        chk("pp_full", {7'b0, fifo_full}, 8'h01);
        for (int k = 0; k < 10; k++) begin
            step(8'h00, 8'h00, 1'b1, 1'b0);
            if (k < 8) chk($sformatf("pp_vol%0d", k), volume, 8'hA0 + 8'(k));
            if (k == 8) chk("pp_vol_last", volume, 8'hAA);
        end
        chk("pp_vol_stay", volume, 8'hAA);
        chk("pp_ovf_end", {7'b0, ovf_err}, 8'h00);

        // unknown code; set wins over same-cycle clear
        step(8'h55, 8'h77, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b1);
        chk("bad_prio", {7'b0, bad_cmd}, 8'h01);
        chk("bad_vol", volume, 8'hAA);
        chk("bad_note", note_num, 8'h3C);
        chk("bad_wave", wave_sel, 8'h05);
        chk("bad_tick", {7'b0, frame_tick}, 8'h00);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        chk("bad_clr", {7'b0, bad_cmd}, 8'h00);

        // mid-operation reset discards queued entries
        for (int i = 0; i < 5; i++) step(8'h41, 8'h10 + 8'(i), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_all_zero("mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(8'h41, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("post_note", note_num, 8'h00);
        chk("post_on", {7'b0, note_on}, 8'h00);
        chk("post_full", {7'b0, fifo_full}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
